pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
Game-flow sequencer for the two-player VGA paddle game. Owns the top-level state (QI / QGAME_1 / QGAME_2 / QDONE), both 4-bit scores, serve timing and ball enable. Consumes frame ticks and miss events from the ball/collision logic. Drives the ball datapath, the LD state indicators and the SSD score digits.

Parameters:
WIN_SCORE, 10, points needed to win (legal range 1..14; the 10 default matches LD0/LD1 test of 4'b1010)
SERVE_DELAY, 60, frame ticks the ball is held at serve position before release (1..255)

Ports:
clk  input  1  system clock (DIV_CLK-derived game clock)
reset  input  1  synchronous, active-high reset
start  input  1  level game-enable (Sw1)
frame_tick  input  1  one-cycle pulse per VGA frame
miss_p1  input  1  one-cycle pulse: ball passed player 1's paddle; point to P2
miss_p2  input  1  one-cycle pulse: ball passed player 2's paddle; point to P1
state  output  2  00=QI, 01=QGAME_1 (P1 serving), 10=QGAME_2 (P2 serving), 11=QDONE
p1_score  output  4  player 1 score
p2_score  output  4  player 2 score
ball_en  output  1  1 = ball may move; 0 = hold at serve position
ball_reset  output  1  one-cycle pulse: recenter ball at serving side
winner  output  2  00 none, 01 P1, 10 P2

Behaviour:
- Reset (sync, active-high, on posedge clk):
  - state=QI, scores=0, ball_en=0, ball_reset=0, winner=00, serve counter=0.
  - Reset has priority over every other input in any state, including mid-serve and mid-rally.
- All outputs are registered. Every response appears on the edge after the causing input is sampled (latency 1 cycle).
- 8-bit serve counter `srv_cnt`:
  - Loaded with SERVE_DELAY whenever ball_reset is asserted.
  - Decrements by 1 on each frame_tick while nonzero.
  - ball_en = (state is QGAME_1 or QGAME_2) and srv_cnt==0, registered.
- QI:
  - Scores held at 0.
  - start=1 -> QGAME_1, ball_reset pulse, srv_cnt=SERVE_DELAY.
- QGAME_1 / QGAME_2:
  - Miss pulses are ignored while ball_en=0 (serve hold).
  - With ball_en=1, miss_p1 alone -> p2_score+1; next server is P1, so state=QGAME_1 plus ball_reset.
  - With ball_en=1, miss_p2 alone -> p1_score+1; next server is P2, so state=QGAME_2 plus ball_reset.
  - Loser of a point always serves.
  - miss_p1 and miss_p2 in the same cycle: no score change, ball_reset pulse, same server re-serves.
  - If the incremented score equals WIN_SCORE -> QDONE instead of a re-serve.
    - winner set (01 or 10), ball_en=0, no ball_reset.
    - Score shows WIN_SCORE and never exceeds it.
  - start=0 in either game state -> abort to QI. Scores cleared, ball_en=0, winner=00.
- QDONE:
  - Scores, winner and state frozen; all miss and frame_tick inputs ignored.
  - start=0 -> QI, clearing scores and winner.
  - A new game requires start to fall and rise again.
- frame_tick arriving in the same cycle as a ball_reset load: the load wins (no decrement that cycle).
- Score arithmetic is 4-bit unsigned and never wraps.

Optional Feature:
WIN_BY_TWO_EN
- Defined:
  - Win requires score >= WIN_SCORE and a lead >= 2.
  - When a point makes the scores equal at >= WIN_SCORE-1 (deuce), both scores are written to WIN_SCORE-1 in that same cycle. This keeps the maximum score at WIN_SCORE+1 and within 4 bits.
  - Win value shown is the leader's score (WIN_SCORE or WIN_SCORE+1).
- Undefined: first to WIN_SCORE wins, as described above; no deuce logic is synthesized.

Test Plan:
- Reset then start=1 -> next cycle: state=01 and ball_reset=1 for exactly 1 cycle; ball_en=0 for 60 frame_ticks, then ball_en=1.
- During serve hold, pulse miss_p2 -> scores unchanged at 0/0, state stays 01.
- After release, miss_p2 -> p1_score=1, state=10, ball_reset pulse; then miss_p1 after release -> p2_score=1, state=01.
- Drive P1 to 9 points, then one more miss_p2 -> p1_score=10 (4'b1010), state=11, winner=01, ball_en=0. Further miss pulses leave all outputs unchanged. start=0 -> state=00, scores 0.
- Simultaneous miss_p1 and miss_p2 at 3/4 in QGAME_2 -> scores stay 3/4, state=10, ball_reset pulse.
- Mid-rally at 5/7: assert reset -> next cycle all outputs at reset values. Separately, at 5/7 drop start -> state=00, scores 0/0.
- With WIN_BY_TWO_EN: reach 9/9, P1 scores -> 10/9. P2 scores -> both forced to 9/9. P1 scores twice -> 10/9 then 11/9, winner=01.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - game-flow sequencer: state, scores, serve timing, ball enable
// Optional deuce/win-by-two rule enabled by defining WIN_BY_TWO_EN.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 10,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       miss_p1,
    input  logic       miss_p2,
    output logic [1:0] state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       ball_en,
    output logic       ball_reset,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [4:0] WIN5 = 5'(WIN_SCORE);
    localparam logic [7:0] SD8  = 8'(SERVE_DELAY);

    state_t     state_q;
    logic [3:0] p1_q, p2_q;
    logic [1:0] winner_q;
    logic       ball_en_q, ball_reset_q;
    logic [7:0] srv_cnt_q;

    logic [7:0] srv_dec;
    logic [3:0] p1_inc, p2_inc;
    logic       p1_win, p2_win;

`ifdef WIN_BY_TWO_EN
    localparam logic [3:0] WIN_M1 = 4'(WIN_SCORE - 1);
    logic p1_deuce, p2_deuce;
`endif

    always_comb begin
        srv_dec = srv_cnt_q;
        if (frame_tick && (srv_cnt_q != 8'd0)) begin
            srv_dec = srv_cnt_q - 8'd1;
        end
        p1_inc = p1_q + 4'd1;
        p2_inc = p2_q + 4'd1;
`ifdef WIN_BY_TWO_EN
        p1_win   = ({1'b0, p1_inc} >= WIN5) && ({1'b0, p1_inc} >= ({1'b0, p2_q} + 5'd2));
        p2_win   = ({1'b0, p2_inc} >= WIN5) && ({1'b0, p2_inc} >= ({1'b0, p1_q} + 5'd2));
        p1_deuce = (p1_inc == p2_q) && (p1_inc >= WIN_M1);
        p2_deuce = (p2_inc == p1_q) && (p2_inc >= WIN_M1);
`else
        p1_win = ({1'b0, p1_inc} == WIN5);
        p2_win = ({1'b0, p2_inc} == WIN5);
`endif
    end

    // ball_en tracks the counter value being written this edge, so it drops
    // together with every ball_reset and rises on the tick that reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= QI;
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            winner_q     <= 2'b00;
            ball_en_q    <= 1'b0;
            ball_reset_q <= 1'b0;
            srv_cnt_q    <= 8'd0;
        end else begin
            ball_reset_q <= 1'b0;
            case (state_q)
                QI: begin
                    p1_q      <= 4'd0;
                    p2_q      <= 4'd0;
                    winner_q  <= 2'b00;
                    ball_en_q <= 1'b0;
                    srv_cnt_q <= srv_dec;
                    if (start) begin
                        state_q      <= QGAME_1;
                        ball_reset_q <= 1'b1;
                        srv_cnt_q    <= SD8;
                    end
                end
                QGAME_1, QGAME_2: begin
                    if (!start) begin
                        state_q   <= QI;
                        p1_q      <= 4'd0;
                        p2_q      <= 4'd0;
                        winner_q  <= 2'b00;
                        ball_en_q <= 1'b0;
                        srv_cnt_q <= srv_dec;
                    end else if (ball_en_q && miss_p1 && miss_p2) begin
                        ball_reset_q <= 1'b1;
                        srv_cnt_q    <= SD8;
                        ball_en_q    <= 1'b0;
                    end else if (ball_en_q && miss_p1) begin
                        ball_en_q <= 1'b0;
                        if (p2_win) begin
                            p2_q      <= p2_inc;
                            state_q   <= QDONE;
                            winner_q  <= 2'b10;
                            srv_cnt_q <= srv_dec;
`ifdef WIN_BY_TWO_EN
                        end else if (p2_deuce) begin
                            p1_q         <= WIN_M1;
                            p2_q         <= WIN_M1;
                            state_q      <= QGAME_1;
                            ball_reset_q <= 1'b1;
                            srv_cnt_q    <= SD8;
`endif
                        end else begin
                            p2_q         <= p2_inc;
                            state_q      <= QGAME_1;
                            ball_reset_q <= 1'b1;
                            srv_cnt_q    <= SD8;
                        end
                    end else if (ball_en_q && miss_p2) begin
                        ball_en_q <= 1'b0;
                        if (p1_win) begin
                            p1_q      <= p1_inc;
                            state_q   <= QDONE;
                            winner_q  <= 2'b01;
                            srv_cnt_q <= srv_dec;
`ifdef WIN_BY_TWO_EN
                        end else if (p1_deuce) begin
                            p1_q         <= WIN_M1;
                            p2_q         <= WIN_M1;
                            state_q      <= QGAME_2;
                            ball_reset_q <= 1'b1;
                            srv_cnt_q    <= SD8;
`endif
                        end else begin
                            p1_q         <= p1_inc;
                            state_q      <= QGAME_2;
                            ball_reset_q <= 1'b1;
                            srv_cnt_q    <= SD8;
                        end
                    end else begin
                        srv_cnt_q <= srv_dec;
                        ball_en_q <= (srv_dec == 8'd0);
                    end
                end
                QDONE: begin
                    ball_en_q <= 1'b0;
                    if (!start) begin
                        state_q  <= QI;
                        p1_q     <= 4'd0;
                        p2_q     <= 4'd0;
                        winner_q <= 2'b00;
                    end
                end
                default: state_q <= QI;
            endcase
        end
    end

    assign state      = state_q;
    assign p1_score   = p1_q;
    assign p2_score   = p2_q;
    assign ball_en    = ball_en_q;
    assign ball_reset = ball_reset_q;
    assign winner     = winner_q;

endmodule
